// File: rtl/fmc_startup_seq.sv
// FMC startup sequencer: settles, writes and reads back NUM_CH I2C expanders with
// retry/timeout handling, then monitors FMC presence until restarted.
module fmc_startup_seq #(
    parameter int unsigned NUM_CH         = 5,
    parameter int unsigned PAUSE_CYCLES   = 125000000,
    parameter int unsigned TIMEOUT_CYCLES = 1250000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter logic [7:0]  BYPASS_TYPE    = 8'h02,
    parameter logic [7:0]  WR_VALUE       = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [7:0]            fmc_mod_type,
    input  logic                  fmc_absent,
    input  logic                  i2c_int_n,
    input  logic                  i2c_error,
    input  logic                  i2c_wr_rdy,
    input  logic [7:0]            i2c_reg_dat,
    input  logic                  i2c_reg_valid,
    input  logic [NUM_CH-1:0]     wr_mask,
    input  logic [NUM_CH-1:0]     rd_mask,
    output logic                  start_write,
    output logic                  start_read,
    output logic [7:0]            wr_ctrl_reg,
    output logic [NUM_CH-1:0]     channel_sel,
    output logic [8*NUM_CH-1:0]   rd_data,
    output logic [2:0]            err_code,
    output logic [2:0]            err_ch,
    output logic [7:0]            retry_total,
    output logic                  sm_running,
    output logic [3:0]            state
);

    localparam int unsigned CNT_MAX = (PAUSE_CYCLES > TIMEOUT_CYCLES) ? PAUSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PRE_WAIT  = 4'd1,
        S_CHECK_ABS = 4'd2,
        S_WR_START  = 4'd3,
        S_WR_WAIT   = 4'd4,
        S_RD_START  = 4'd5,
        S_RD_WAIT   = 4'd6,
        S_POST_WAIT = 4'd7,
        S_CHECK_INT = 4'd8,
        S_MONITOR   = 4'd9,
        S_ERROR     = 4'd10
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [2:0]         ch_q, ch_nxt;
    logic [2:0]         rcnt_q, rcnt_nxt;
    logic [2:0]         err_code_nxt, err_ch_nxt;
    logic [7:0]         retry_nxt;
    logic [8*NUM_CH-1:0] rd_data_nxt;
    logic               do_retry, retry_is_to, in_txn;
    logic [3:0]         wr_first, wr_next, rd_first, rd_next;

    // Lowest set mask bit at or above 'from'; bit 3 flags that one was found.
    function automatic logic [3:0] find_from(input logic [NUM_CH-1:0] m, input int from);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!r[3] && m[i] && i >= from) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign wr_first = find_from(wr_mask, 0);
    assign wr_next  = find_from(wr_mask, int'(ch_q) + 1);
    assign rd_first = find_from(rd_mask, 0);
    assign rd_next  = find_from(rd_mask, int'(ch_q) + 1);
    assign state    = state_q;

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        ch_nxt       = ch_q;
        rcnt_nxt     = rcnt_q;
        err_code_nxt = err_code;
        err_ch_nxt   = err_ch;
        retry_nxt    = retry_total;
        rd_data_nxt  = rd_data;
        do_retry     = 1'b0;
        retry_is_to  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_nxt      = CNT_W'(PAUSE_CYCLES - 1);
                ch_nxt       = 3'd0;
                rcnt_nxt     = 3'd0;
                err_code_nxt = 3'd0;
                err_ch_nxt   = 3'd0;
                retry_nxt    = 8'd0;
                state_nxt    = S_PRE_WAIT;
            end
            S_PRE_WAIT, S_POST_WAIT: begin
                if (cnt_q == '0) state_nxt = (state_q == S_PRE_WAIT) ? S_CHECK_ABS : S_CHECK_INT;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            S_CHECK_ABS: begin
                if (fmc_absent) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = 3'd2;
                end else if (fmc_mod_type == BYPASS_TYPE) begin
                    state_nxt = S_MONITOR;
                end else if (wr_first[3]) begin
                    ch_nxt    = wr_first[2:0];
                    state_nxt = S_WR_START;
                end else if (rd_first[3]) begin
                    ch_nxt    = rd_first[2:0];
                    state_nxt = S_RD_START;
                end else begin
                    state_nxt = S_POST_WAIT;
                end
            end
            S_WR_START, S_RD_START: begin
                cnt_nxt   = CNT_W'(TIMEOUT_CYCLES);
                state_nxt = (state_q == S_WR_START) ? S_WR_WAIT : S_RD_WAIT;
            end
            S_WR_WAIT: begin
                if (i2c_error) begin
                    do_retry = 1'b1;
                end else if (i2c_wr_rdy) begin
                    rcnt_nxt = 3'd0;
                    if (wr_next[3]) begin
                        ch_nxt    = wr_next[2:0];
                        state_nxt = S_WR_START;
                    end else if (rd_first[3]) begin
                        ch_nxt    = rd_first[2:0];
                        state_nxt = S_RD_START;
                    end else begin
                        state_nxt = S_POST_WAIT;
                    end
                end else if (cnt_q <= CNT_W'(1)) begin
                    do_retry    = 1'b1;
                    retry_is_to = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            S_RD_WAIT: begin
                if (i2c_error) begin
                    do_retry = 1'b1;
                end else if (i2c_reg_valid) begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        if (ch_q == 3'(i)) rd_data_nxt[8*i +: 8] = i2c_reg_dat;
                    end
                    rcnt_nxt = 3'd0;
                    if (ch_q == 3'd0 && i2c_reg_dat != fmc_mod_type) begin
                        state_nxt    = S_ERROR;
                        err_code_nxt = 3'd3;
                        err_ch_nxt   = 3'd0;
                    end else if (rd_next[3]) begin
                        ch_nxt    = rd_next[2:0];
                        state_nxt = S_RD_START;
                    end else begin
                        state_nxt = S_POST_WAIT;
                    end
                end else if (cnt_q <= CNT_W'(1)) begin
                    do_retry    = 1'b1;
                    retry_is_to = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK_INT: begin
                if (i2c_int_n) begin
                    state_nxt = S_MONITOR;
                end else begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = 3'd4;
                end
            end
            S_MONITOR: begin
                if (fmc_absent) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = 3'd2;
                end else if (restart) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                if (restart) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Shared retry/exhaustion handling for both transaction phases.
        if (do_retry) begin
            if (rcnt_q < 3'(MAX_RETRY)) begin
                rcnt_nxt  = rcnt_q + 3'd1;
                retry_nxt = (retry_total == 8'hFF) ? retry_total : retry_total + 8'd1;
                state_nxt = (state_q == S_RD_WAIT) ? S_RD_START : S_WR_START;
            end else begin
                state_nxt    = S_ERROR;
                err_code_nxt = retry_is_to ? 3'd5 : 3'd1;
                err_ch_nxt   = ch_q;
            end
        end

        if (state_nxt == S_POST_WAIT && state_q != S_POST_WAIT) cnt_nxt = CNT_W'(PAUSE_CYCLES - 1);
    end

    assign in_txn = (state_nxt == S_WR_START) || (state_nxt == S_WR_WAIT) ||
                    (state_nxt == S_RD_START) || (state_nxt == S_RD_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ch_q        <= 3'd0;
            rcnt_q      <= 3'd0;
            err_code    <= 3'd0;
            err_ch      <= 3'd0;
            retry_total <= 8'd0;
            rd_data     <= '0;
            start_write <= 1'b0;
            start_read  <= 1'b0;
            channel_sel <= '0;
            sm_running  <= 1'b1;
            wr_ctrl_reg <= WR_VALUE;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            ch_q        <= ch_nxt;
            rcnt_q      <= rcnt_nxt;
            err_code    <= err_code_nxt;
            err_ch      <= err_ch_nxt;
            retry_total <= retry_nxt;
            rd_data     <= rd_data_nxt;
            start_write <= (state_nxt == S_WR_START);
            start_read  <= (state_nxt == S_RD_START);
            channel_sel <= in_txn ? (NUM_CH'(1) << ch_nxt) : '0;
            sm_running  <= !((state_nxt == S_MONITOR) || (state_nxt == S_ERROR));
            wr_ctrl_reg <= WR_VALUE;
        end
    end

endmodule

// File: tb/tb_fmc_startup_seq.sv
// Scoreboard bench for fmc_startup_seq: expected start requests are queued per test and
// popped as the DUT issues them; a small I2C responder model answers each request.
module tb_fmc_startup_seq;

    localparam int unsigned NCH   = 5;
    localparam int unsigned PAUSE = 16;
    localparam int unsigned TMO   = 20;
    localparam int unsigned MAXR  = 2;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_PRE = 4'd1, ST_MONITOR = 4'd9, ST_ERROR = 4'd10;

    logic              clk, reset, restart;
    logic [7:0]        fmc_mod_type;
    logic              fmc_absent, i2c_int_n, i2c_error, i2c_wr_rdy, i2c_reg_valid;
    logic [7:0]        i2c_reg_dat;
    logic [NCH-1:0]    wr_mask, rd_mask;
    logic              start_write, start_read;
    logic [7:0]        wr_ctrl_reg;
    logic [NCH-1:0]    channel_sel;
    logic [8*NCH-1:0]  rd_data;
    logic [2:0]        err_code, err_ch;
    logic [7:0]        retry_total;
    logic              sm_running;
    logic [3:0]        state;

    fmc_startup_seq #(
        .NUM_CH(NCH), .PAUSE_CYCLES(PAUSE), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR),
        .BYPASS_TYPE(8'h02), .WR_VALUE(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .fmc_mod_type(fmc_mod_type),
        .fmc_absent(fmc_absent), .i2c_int_n(i2c_int_n), .i2c_error(i2c_error),
        .i2c_wr_rdy(i2c_wr_rdy), .i2c_reg_dat(i2c_reg_dat), .i2c_reg_valid(i2c_reg_valid),
        .wr_mask(wr_mask), .rd_mask(rd_mask), .start_write(start_write),
        .start_read(start_read), .wr_ctrl_reg(wr_ctrl_reg), .channel_sel(channel_sel),
        .rd_data(rd_data), .err_code(err_code), .err_ch(err_ch),
        .retry_total(retry_total), .sm_running(sm_running), .state(state)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    logic [6:0] exp_q[$];
    int t3_q[$];
    int extra_starts = 0;
    logic [7:0] rd0_val;
    int wr_err_ch2, nv_ch;

    initial clk = 1'b0;
    always #4 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic is_rd, input int ch);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << ch;
        exp_q.push_back({!is_rd, is_rd, oh});
    endtask

    task automatic wait_state(input logic [3:0] tgt, input int budget, input string tag);
        int n = 0;
        while (state !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, state, tgt);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        restart = 1'b0;
        exp_q.delete();
        t3_q.delete();
        extra_starts = 0;
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: every start pulse must match the next queued request.
    initial forever begin
        logic [6:0] obs, e;
        @(negedge clk);
        if (!reset && (start_write || start_read)) begin
            obs = {start_write, start_read, channel_sel};
            if (start_read && channel_sel == 5'b01000) t3_q.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("start_tx", obs, e);
            end else begin
                extra_starts++;
            end
        end
    end

    // I2C master model: answers three cycles after each request.
    initial begin
        int pend, pkind, presp, pch, ch;
        int wr_att[8], rd_att[8];
        pend = 0; pkind = 0; presp = 0; pch = 0;
        for (int i = 0; i < 8; i++) begin wr_att[i] = 0; rd_att[i] = 0; end
        i2c_error = 1'b0; i2c_wr_rdy = 1'b0; i2c_reg_valid = 1'b0; i2c_reg_dat = 8'h00;
        forever begin
            @(negedge clk);
            i2c_error = 1'b0; i2c_wr_rdy = 1'b0; i2c_reg_valid = 1'b0;
            if (reset) begin
                pend = 0;
                for (int i = 0; i < 8; i++) begin wr_att[i] = 0; rd_att[i] = 0; end
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        if (presp == 1) i2c_error = 1'b1;
                        else if (presp == 0) begin
                            if (pkind == 0) i2c_wr_rdy = 1'b1;
                            else begin
                                i2c_reg_valid = 1'b1;
                                i2c_reg_dat = (pch == 0) ? rd0_val : 8'(8'hA0 + pch);
                            end
                        end
                    end
                end
                if (start_write || start_read) begin
                    ch = 0;
                    for (int i = 0; i < int'(NCH); i++) if (channel_sel[i]) ch = i;
                    pch = ch;
                    pend = 3;
                    if (start_write) begin
                        pkind = 0;
                        wr_att[ch]++;
                        presp = (ch == 2 && wr_att[ch] <= wr_err_ch2) ? 1 : 0;
                    end else begin
                        pkind = 1;
                        rd_att[ch]++;
                        presp = (ch == nv_ch) ? 2 : 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; restart = 1'b0; fmc_mod_type = 8'h01; fmc_absent = 1'b0;
        i2c_int_n = 1'b1; wr_mask = 5'h1F; rd_mask = 5'h1F;
        rd0_val = 8'h01; wr_err_ch2 = 0; nv_ch = -1;

        // Reset state
        apply_reset();
        check_eq("rst_state", state, ST_IDLE);
        check_eq("rst_running", sm_running, 1'b1);
        check_eq("rst_starts", {start_write, start_read}, 2'b00);
        check_eq("rst_chsel", channel_sel, 0);
        check_eq("rst_err", {err_code, err_ch}, 0);
        check_eq("rst_retry", retry_total, 0);
        check_eq("rst_rddata", rd_data, 0);

        // Normal startup, all channels
        for (int i = 0; i < 5; i++) push_tx(1'b0, i);
        for (int i = 0; i < 5; i++) push_tx(1'b1, i);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t1_pre_wait", state, ST_PRE);
        wait_state(ST_MONITOR, 400, "t1_monitor");
        check_eq("t1_err", err_code, 0);
        check_eq("t1_running", sm_running, 1'b0);
        check_eq("t1_rddata", rd_data, 40'hA4A3A2A101);
        check_eq("t1_wrctrl", wr_ctrl_reg, 8'hFF);
        check_eq("t1_sb_left", exp_q.size(), 0);
        check_eq("t1_extra", extra_starts, 0);

        // Bypass type, then module removal
        apply_reset();
        fmc_mod_type = 8'h02;
        reset = 1'b0;
        wait_state(ST_MONITOR, 100, "t2_monitor");
        check_eq("t2_extra", extra_starts, 0);
        fmc_absent = 1'b1;
        wait_state(ST_ERROR, 10, "t2_error");
        check_eq("t2_err", err_code, 3'd2);
        check_eq("t2_running", sm_running, 1'b0);
        fmc_absent = 1'b0;

        // Two write errors on ch2, third attempt succeeds
        apply_reset();
        fmc_mod_type = 8'h01; wr_err_ch2 = 2;
        push_tx(1'b0, 0); push_tx(1'b0, 1);
        push_tx(1'b0, 2); push_tx(1'b0, 2); push_tx(1'b0, 2);
        push_tx(1'b0, 3); push_tx(1'b0, 4);
        for (int i = 0; i < 5; i++) push_tx(1'b1, i);
        reset = 1'b0;
        wait_state(ST_MONITOR, 500, "t3_monitor");
        check_eq("t3_retry", retry_total, 8'd2);
        check_eq("t3_err", err_code, 0);
        check_eq("t3_sb_left", exp_q.size(), 0);
        check_eq("t3_extra", extra_starts, 0);

        // Read timeout exhaustion on ch3
        apply_reset();
        wr_err_ch2 = 0; nv_ch = 3;
        for (int i = 0; i < 5; i++) push_tx(1'b0, i);
        push_tx(1'b1, 0); push_tx(1'b1, 1); push_tx(1'b1, 2);
        push_tx(1'b1, 3); push_tx(1'b1, 3); push_tx(1'b1, 3);
        reset = 1'b0;
        wait_state(ST_ERROR, 600, "t4_error");
        check_eq("t4_err", {err_code, err_ch}, {3'd5, 3'd3});
        check_eq("t4_retry", retry_total, 8'd2);
        check_eq("t4_npulses", t3_q.size(), 3);
        if (t3_q.size() == 3) begin
            check_eq("t4_gap0", t3_q[1] - t3_q[0], TMO + 1);
            check_eq("t4_gap1", t3_q[2] - t3_q[1], TMO + 1);
        end
        check_eq("t4_sb_left", exp_q.size(), 0);

        // Partial masks with a type mismatch, then restart
        apply_reset();
        nv_ch = -1; wr_mask = 5'b00101; rd_mask = 5'b00001; rd0_val = 8'h07;
        push_tx(1'b0, 0); push_tx(1'b0, 2); push_tx(1'b1, 0);
        reset = 1'b0;
        wait_state(ST_ERROR, 300, "t5_error");
        check_eq("t5_err", {err_code, err_ch}, {3'd3, 3'd0});
        check_eq("t5_rd0", rd_data[7:0], 8'h07);
        check_eq("t5_sb_left", exp_q.size(), 0);
        rd0_val = 8'h01;
        push_tx(1'b0, 0); push_tx(1'b0, 2); push_tx(1'b1, 0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_eq("t5_restart_idle", state, ST_IDLE);
        @(negedge clk);
        check_eq("t5_err_cleared", err_code, 0);
        wait_state(ST_MONITOR, 300, "t5_monitor");
        check_eq("t5_rd0_rerun", rd_data[7:0], 8'h01);
        check_eq("t5_sb_left2", exp_q.size(), 0);
        check_eq("t5_extra", extra_starts, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
